// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter putting I-cache and D-cache line traffic onto one physical-memory port.
// Optional performance counters are compiled in when ARB_PERF_CNT_EN is defined.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_contention
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RECOVER} state_t;
    typedef enum logic {CLIENT_I, CLIENT_D} client_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-5){1'b1}}, 5'b0};

    state_t  state;
    client_t last_grant;
    logic    i_req;
    logic    d_req;
    logic    grant_i;
    logic    grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // On a tie the client that was not served last wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                grant_d = (last_grant == CLIENT_I);
                grant_i = (last_grant == CLIENT_D);
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= CLIENT_I;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= GRANT_D;
                        mem_address <= d_pmem_address & LINE_MASK;
                        mem_wdata   <= d_pmem_wdata;
                        mem_write   <= d_pmem_write;
                        mem_read    <= ~d_pmem_write;
                    end else if (grant_i) begin
                        state       <= GRANT_I;
                        mem_address <= i_pmem_address & LINE_MASK;
                        mem_wdata   <= '0;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (mem_resp) begin
                        state      <= RECOVER;
                        last_grant <= CLIENT_I;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (mem_resp) begin
                        state      <= RECOVER;
                        last_grant <= CLIENT_D;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                    end
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Responses are steered combinationally so the client sees them in the mem_resp cycle.
    assign i_pmem_resp  = ~rst && (state == GRANT_I) && mem_resp;
    assign d_pmem_resp  = ~rst && (state == GRANT_D) && mem_resp;
    assign i_pmem_rdata = (~rst && (state == GRANT_I)) ? mem_rdata : '0;
    assign d_pmem_rdata = (~rst && (state == GRANT_D)) ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_grants   <= '0;
            perf_d_grants   <= '0;
            perf_contention <= '0;
        end else begin
            if (grant_i && (perf_i_grants != '1))
                perf_i_grants <= perf_i_grants + 32'd1;
            if (grant_d && (perf_d_grants != '1))
                perf_d_grants <= perf_d_grants + 32'd1;
            if ((state == IDLE) && i_req && d_req && (perf_contention != '1))
                perf_contention <= perf_contention + 32'd1;
        end
    end
`else
    assign perf_i_grants   = '0;
    assign perf_d_grants   = '0;
    assign perf_contention = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed vector table, corner sequences,
// and a randomized run against a transaction-level arbitration and memory model.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  perf_i_grants;
    logic [31:0]  perf_d_grants;
    logic [31:0]  perf_contention;

    cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_contention(perf_contention)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] PAT_A = {8{32'hA5A5_0001}};
    localparam logic [255:0] PAT_B = {8{32'hB00B_1E55}};
    localparam logic [255:0] PAT_C = {8{32'hC0DE_CAFE}};
    localparam logic [255:0] PAT_D = {4{64'hDEAD_BEEF_0123_4567}};

    int checks = 0;
    int errors = 0;

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        mem_rdata      = '0;
        mem_resp       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Directed single-transaction vectors.
    typedef struct {
        bit           is_d;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int unsigned  lat;
        logic [31:0]  exp_addr;
        bit           exp_rd;
        bit           exp_wr;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        if (v.is_d) begin
            d_pmem_read    = v.rd;
            d_pmem_write   = v.wr;
            d_pmem_address = v.addr;
            d_pmem_wdata   = v.wdata;
        end else begin
            i_pmem_read    = 1'b1;
            i_pmem_address = v.addr;
        end
        tick();
        chkb("vec_mem_read", mem_read, v.exp_rd);
        chkb("vec_mem_write", mem_write, v.exp_wr);
        chka("vec_mem_address", mem_address, v.exp_addr);
        if (v.exp_wr) chkd("vec_mem_wdata", mem_wdata, v.wdata);
        // Disturb the request fields; the latched values must not move.
        i_pmem_address = ~i_pmem_address;
        d_pmem_address = ~d_pmem_address;
        d_pmem_wdata   = ~d_pmem_wdata;
        for (int unsigned k = 0; k < v.lat; k++) tick();
        mem_resp  = 1'b1;
        mem_rdata = v.rdata;
        #1;
        chka("vec_addr_hold", mem_address, v.exp_addr);
        if (v.exp_wr) chkd("vec_wdata_hold", mem_wdata, v.wdata);
        chkb("vec_i_resp", i_pmem_resp, !v.is_d);
        chkb("vec_d_resp", d_pmem_resp, v.is_d);
        chkd("vec_granted_rdata", v.is_d ? d_pmem_rdata : i_pmem_rdata, v.rdata);
        chkd("vec_other_rdata", v.is_d ? i_pmem_rdata : d_pmem_rdata, '0);
        tick();
        mem_resp     = 1'b0;
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        #1;
        chkb("vec_recover_read", mem_read, 1'b0);
        chkb("vec_recover_write", mem_write, 1'b0);
        chkb("vec_resp_pulse_i", i_pmem_resp, 1'b0);
        chkb("vec_resp_pulse_d", d_pmem_resp, 1'b0);
        tick();
    endtask

    // Wait (bounded) for a memory op, check it, then complete it and step into RECOVER.
    task automatic serve(input string name, input logic [31:0] exp_addr, input bit exp_rd,
                         input bit exp_wr, input bit to_d, input logic [255:0] rdata,
                         output int waited);
        waited = 0;
        while (!(mem_read || mem_write) && waited < 20) begin
            tick();
            waited++;
        end
        chka({name, "_addr"}, mem_address, exp_addr);
        chkb({name, "_rd"}, mem_read, exp_rd);
        chkb({name, "_wr"}, mem_write, exp_wr);
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        #1;
        chkb({name, "_i_resp"}, i_pmem_resp, !to_d);
        chkb({name, "_d_resp"}, d_pmem_resp, to_d);
        chkd({name, "_rdata"}, to_d ? d_pmem_rdata : i_pmem_rdata, rdata);
        tick();
        mem_resp = 1'b0;
    endtask

    task automatic seq_tie();
        int w;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0104;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h8000_0208;
        serve("tie_first_d", 32'h8000_0200, 1'b1, 1'b0, 1'b1, PAT_C, w);
        chka("tie_first_latency", 32'(w), 32'd1);
        d_pmem_read = 1'b0;
        serve("tie_then_i", 32'h0000_0100, 1'b1, 1'b0, 1'b0, PAT_A, w);
        chka("tie_gap_cycles", 32'(w), 32'd2);
        i_pmem_read = 1'b0;
        tick();
    endtask

    // Reference memory for the randomized run.
    logic [255:0] mem_arr [logic [31:0]];

    function automatic logic [255:0] mem_get(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 5) | ($urandom & 32'h1F);
        return a;
    endfunction

    task automatic run_random(input int cycles);
        bit           i_act, d_act, i_done, d_done;
        logic [31:0]  i_a, d_a;
        bit           d_r, d_w;
        logic [255:0] d_wd, exp_rd_line;
        int           owner, last, cool, lat, gi, gd, gc;
        int           i_wait, d_wait, max_wait;
        logic         m_rd, m_wr;
        logic [31:0]  m_addr;
        logic [255:0] m_wd;
        bit           ri, rq, ei, ed;
        int           win, op;
        i_act = 0; d_act = 0; i_done = 0; d_done = 0;
        i_a = '0; d_a = '0; d_r = 0; d_w = 0; d_wd = '0; exp_rd_line = '0;
        owner = 0; last = 1; cool = 0; lat = 0; gi = 0; gd = 0; gc = 0;
        i_wait = 0; d_wait = 0; max_wait = 0;
        m_rd = 0; m_wr = 0; m_addr = '0; m_wd = '0;
        for (int c = 0; c < cycles; c++) begin
            chkb("rnd_mem_read", mem_read, m_rd);
            chkb("rnd_mem_write", mem_write, m_wr);
            if (owner != 0) chka("rnd_mem_address", mem_address, m_addr);
            if (m_wr) chkd("rnd_mem_wdata", mem_wdata, m_wd);
            if (i_done) begin i_act = 0; i_done = 0; end
            if (d_done) begin d_act = 0; d_done = 0; end
            if (!i_act && $urandom_range(0, 3) == 0) begin
                i_act = 1;
                i_a   = rand_addr();
            end
            if (!d_act && $urandom_range(0, 3) == 0) begin
                d_act = 1;
                d_a   = rand_addr();
                op    = int'($urandom_range(0, 2));
                d_r   = (op != 1);
                d_w   = (op != 0);
                d_wd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            i_pmem_read    = i_act;
            i_pmem_address = i_act ? i_a : $urandom;
            d_pmem_read    = d_act && d_r;
            d_pmem_write   = d_act && d_w;
            d_pmem_address = d_act ? d_a : $urandom;
            d_pmem_wdata   = d_act ? d_wd : {8{$urandom}};
            mem_resp  = 1'b0;
            mem_rdata = {8{$urandom}};
            if (owner != 0) begin
                if (lat == 0) begin
                    mem_resp = 1'b1;
                    if (!m_wr) mem_rdata = mem_get(m_addr);
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_resp = 1'b1;
            end
            exp_rd_line = mem_rdata;
            #1;
            ei = mem_resp && owner == 1;
            ed = mem_resp && owner == 2;
            chkb("rnd_i_resp", i_pmem_resp, ei);
            chkb("rnd_d_resp", d_pmem_resp, ed);
            if (ei) chkd("rnd_i_rdata", i_pmem_rdata, mem_get(m_addr));
            if (ed && !m_wr) chkd("rnd_d_rdata", d_pmem_rdata, exp_rd_line);
            if (owner != 1) chkd("rnd_i_rdata_idle", i_pmem_rdata, '0);
            if (owner != 2) chkd("rnd_d_rdata_idle", d_pmem_rdata, '0);
            if (ei) i_done = 1;
            if (ed) begin
                d_done = 1;
                if (m_wr) mem_arr[m_addr] = m_wd;
            end
            if (i_act && owner != 1) i_wait++; else i_wait = 0;
            if (d_act && owner != 2) d_wait++; else d_wait = 0;
            if (i_wait > max_wait) max_wait = i_wait;
            if (d_wait > max_wait) max_wait = d_wait;
            // Arbitration decision for the coming edge.
            if (owner != 0) begin
                if (mem_resp) begin
                    last  = owner;
                    owner = 0;
                    m_rd  = 0;
                    m_wr  = 0;
                    cool  = 1;
                end
            end else if (cool > 0) begin
                cool--;
            end else begin
                ri  = i_pmem_read;
                rq  = d_pmem_read || d_pmem_write;
                win = 0;
                if (ri && rq) begin
                    gc++;
                    win = (last == 1) ? 2 : 1;
                end else if (ri) win = 1;
                else if (rq) win = 2;
                if (win == 1) begin
                    owner = 1; gi++;
                    m_addr = i_pmem_address & 32'hFFFF_FFE0;
                    m_rd = 1; m_wr = 0;
                    lat = int'($urandom_range(0, 3));
                end else if (win == 2) begin
                    owner = 2; gd++;
                    m_addr = d_pmem_address & 32'hFFFF_FFE0;
                    m_wr = d_pmem_write;
                    m_rd = !d_pmem_write;
                    m_wd = d_pmem_wdata;
                    lat = int'($urandom_range(0, 3));
                end
            end
            tick();
        end
        chkb("rnd_no_starvation", max_wait <= 16, 1'b1);
        chkb("rnd_activity", (gi > 20) && (gd > 20) && (gc > 5), 1'b1);
`ifdef ARB_PERF_CNT_EN
        chka("rnd_perf_i", perf_i_grants, 32'(gi));
        chka("rnd_perf_d", perf_d_grants, 32'(gd));
        chka("rnd_perf_contention", perf_contention, 32'(gc));
`else
        chka("rnd_perf_i", perf_i_grants, 32'd0);
        chka("rnd_perf_d", perf_d_grants, 32'd0);
        chka("rnd_perf_contention", perf_contention, 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, '0, PAT_A, 5, 32'h0000_1220, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h8000_00E0, PAT_B, PAT_C, 3, 32'h8000_00E0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h1234_567F, PAT_A, PAT_D, 1, 32'h1234_5660, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, PAT_C, PAT_B, 2, 32'hFFFF_FFE0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, '0, PAT_D, 0, 32'hFFFF_FFE0, 1'b1, 1'b0};

        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        chkb("reset_mem_read", mem_read, 1'b0);
        chkb("reset_mem_write", mem_write, 1'b0);
        chka("reset_mem_address", mem_address, '0);
        chkd("reset_mem_wdata", mem_wdata, '0);
        chkb("reset_i_resp", i_pmem_resp, 1'b0);
        chkb("reset_d_resp", d_pmem_resp, 1'b0);
        chkd("reset_i_rdata", i_pmem_rdata, '0);
        chkd("reset_d_rdata", d_pmem_rdata, '0);
        chka("reset_perf_i", perf_i_grants, '0);
        rst = 1'b0;

        // Counter scenario: one tie (D then I), then two I and one D transaction.
        seq_tie();
        run_vec(vecs[0]);
        run_vec(vecs[4]);
        run_vec(vecs[1]);
`ifdef ARB_PERF_CNT_EN
        chka("perf_i_grants", perf_i_grants, 32'd3);
        chka("perf_d_grants", perf_d_grants, 32'd2);
        chka("perf_contention", perf_contention, 32'd1);
`else
        chka("perf_i_grants", perf_i_grants, 32'd0);
        chka("perf_d_grants", perf_d_grants, 32'd0);
        chka("perf_contention", perf_contention, 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Alternation: the second tie after I was served goes to D again.
        do_reset();
        seq_tie();
        seq_tie();

        // Writeback then fill from D while I waits: D-write, I-read, D-read.
        do_reset();
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h8000_0400;
        d_pmem_wdata   = PAT_B;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0500;
        serve("wbf_d_write", 32'h8000_0400, 1'b0, 1'b1, 1'b1, PAT_A, w);
        d_pmem_write   = 1'b0;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h8000_0600;
        serve("wbf_i_read", 32'h0000_0500, 1'b1, 1'b0, 1'b0, PAT_C, w);
        i_pmem_read = 1'b0;
        serve("wbf_d_read", 32'h8000_0600, 1'b1, 1'b0, 1'b1, PAT_D, w);
        d_pmem_read = 1'b0;
        tick();

        // Reset in the middle of an I grant, stray response right after.
        do_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0700;
        tick();
        chkb("rst_mid_granted", mem_read, 1'b1);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        i_pmem_read = 1'b0;
        mem_resp    = 1'b1;
        mem_rdata   = PAT_A;
        #1;
        chkb("rst_mid_mem_read", mem_read, 1'b0);
        chka("rst_mid_mem_address", mem_address, '0);
        chkb("rst_mid_i_resp", i_pmem_resp, 1'b0);
        chkb("rst_mid_d_resp", d_pmem_resp, 1'b0);
        chkd("rst_mid_i_rdata", i_pmem_rdata, '0);
        tick();
        mem_resp = 1'b0;
        chkb("rst_mid_stays_idle", mem_read, 1'b0);

        do_reset();
        run_random(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache control/datapath pairs and upstream of physical memory (L2/DRAM model).
- Arbitrates the two caches' 256-bit line-fill and writeback requests onto a single physical-memory port.
- Latches the winner's address/data and forwards the memory response and read line back to the granted cache only.
- Round-robin fairness on contention.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_W, 256, cache line width (32-byte lines; address bits [4:0] always zero on the memory port).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_pmem_read  in  1  I-cache line-fill request; held high until i_pmem_resp.
- i_pmem_address  in  ADDR_W  I-cache line address.
- i_pmem_rdata  out  LINE_W  line returned to I-cache.
- i_pmem_resp  out  1  I-cache transaction complete.
- d_pmem_read  in  1  D-cache line-fill request; held until d_pmem_resp.
- d_pmem_write  in  1  D-cache writeback request; held until d_pmem_resp.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache writeback line.
- d_pmem_rdata  out  LINE_W  line returned to D-cache.
- d_pmem_resp  out  1  D-cache transaction complete.
- mem_read  out  1  physical memory read strobe.
- mem_write  out  1  physical memory write strobe.
- mem_address  out  ADDR_W  physical address, bits [4:0] forced 0.
- mem_wdata  out  LINE_W  write line.
- mem_rdata  in  LINE_W  read line.
- mem_resp  in  1  memory completion pulse, one cycle.
- perf_i_grants, perf_d_grants, perf_contention  out  32 each  performance counters (see Optional Feature).

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RECOVER.
- IDLE, only one client requesting: grant it. Next state is GRANT_I or GRANT_D.
- IDLE, both requesting: grant the client not in last_grant. last_grant resets to I, so D wins the first tie.
- On the grant edge, register the winner's address (with [4:0] zeroed), wdata and op into mem_* outputs. mem_read/mem_write are asserted from the cycle after the request is first seen in IDLE. Minimum latency is request cycle + 1.
- D-cache request with both d_pmem_read and d_pmem_write high: write takes precedence, and only mem_write is driven.
- GRANT_x: hold mem_* stable until mem_resp. Registered values do not follow later input changes.
- On mem_resp, in the same cycle (combinational):
  - x_pmem_resp = 1 and x_pmem_rdata = mem_rdata.
  - The other client's resp stays 0. The other client's rdata is held at 0 when not granted.
- On the mem_resp edge: clear mem_read/mem_write, update last_grant = x, go to RECOVER.
- RECOVER: one cycle, no grant. Lets the client deassert its request or present a follow-on request (e.g. writeback then fill). Then go to IDLE.
- Back-to-back requests from one client while the other is idle: each is serviced. Per-transaction overhead is 2 idle cycles (RECOVER + IDLE decision).
- Client drops its request before mem_resp (illegal): the transaction still completes on memory, and resp is still pulsed to that client.
- Reset (any state, including mid-transaction):
  - Next cycle: state IDLE, last_grant = I.
  - All mem_* outputs 0.
  - Both resp outputs 0, both rdata outputs 0.
  - Any in-flight memory response is ignored.
- mem_resp arriving in IDLE or RECOVER is ignored: no client resp.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - perf_i_grants and perf_d_grants increment by 1 on each grant.
  - perf_contention increments on every IDLE cycle where both clients request.
  - All counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: counter logic is not compiled, and the perf_* ports are tied to 0.

Test Plan:
- I-only: i_pmem_read=1, addr 0x0000_1234 → mem_read=1, mem_address=0x0000_1220 next cycle. Memory resp after 5 cycles with rdata=pattern A → i_pmem_resp pulses 1 cycle with rdata=A; d_pmem_resp stays 0.
- D writeback: d_pmem_write=1, addr 0x8000_00E0, wdata=B → mem_write=1, mem_wdata=B. On resp → d_pmem_resp=1, RECOVER, then IDLE.
- Simultaneous requests after reset → D granted first. On completion I is granted with no third party intervening. Repeat the tie → D granted again (alternation).
- Writeback→fill sequence from D with I also requesting → order D-write, I-read, D-read; no starvation.
- rst asserted mid-GRANT_I with mem_resp arriving next cycle → mem_read=0 and i_pmem_resp=0 after reset; the stray resp is ignored.
- With ARB_PERF_CNT_EN: 3 I grants, 2 D grants, 1 contention cycle → counters read 3, 2, 1. Without the macro, all perf_* read 0.
